// File: rtl/seg_scan_reader_if.sv
// Change-event handshake bundle for seg_scan_reader.
// Master drives the event payload; slave returns ready.
interface seg_scan_reader_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_digit;
  logic [3:0] out_value;
  logic       out_blank;
  logic       out_err;

  modport master (
    output out_valid, out_digit, out_value,
    output out_blank, out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_digit, out_value,
    input  out_blank, out_err,
    output out_ready
  );
endinterface

// File: rtl/seg_scan_reader.sv
// Multiplexed 7-segment bus reader: recovers per-digit values
// and reports changes through a single-entry event buffer.
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  parameter bit DIG_ACT_HIGH  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    al,
  input  logic [2:0]              version,
  output logic [4*NUM_DIGITS-1:0] digit_value,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  seg_scan_reader_if.master       ev,
  output logic                    frame_done,
  output logic                    ovf,
  input  logic                    clr_ovf
);

  localparam logic [3:0] STB = 4'(STABLE_CYCLES);

  logic [6:0]              seg_s1_q, seg_s2_q, pat_prev_q;
  logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q, sel_prev_q;
  logic [3:0]              run_q, run_d;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   blank_q, err_q;
  logic                    ev_valid_q, ev_blank_q, ev_err_q;
  logic [2:0]              ev_digit_q;
  logic [3:0]              ev_value_q;
  logic                    frame_q, ovf_q;

  logic [6:0]            pat;
  logic [NUM_DIGITS-1:0] sel;
  logic                  one, same, capture, chg;
  logic [2:0]            idx;
  logic [3:0]            cur_val;
  logic                  cur_blank, cur_err;
  logic [5:0]            dec;

  // Returns {err, blank, value}; extended codes win over digits.
  function automatic logic [5:0] decode(
    input logic [6:0] p,
    input logic [2:0] v
  );
    logic [41:0] tab;
    int          n;
    logic [3:0]  x;
    logic        hit;
    logic        bl;
    logic        er;
    tab = '0;
    n   = 0;
    x   = 4'd0;
    hit = 1'b0;
    bl  = 1'b0;
    er  = 1'b0;
    case (v)
      3'd1: begin
        tab = {7'h58, 7'h4C, 7'h62, 7'h69, 7'h78, 7'h00};
        n   = 5;
      end
      3'd2: begin
        tab = {7'h5C, 7'h63, 7'h01, 7'h40, 7'h08, 7'h00};
        n   = 5;
      end
      3'd4: begin
        tab = {7'h08, 7'h48, 7'h49, 7'h41, 7'h01, 7'h00};
        n   = 5;
      end
      3'd5: begin
        tab = {7'h40, 7'h38, 7'h39, 7'h31, 7'h79, 7'h00};
        n   = 5;
      end
      3'd6: begin
        tab = {7'h40, 7'h79, 7'h76, 7'h38, 7'h73, 7'h00};
        n   = 5;
      end
      3'd7: begin
        tab = {7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        n   = 6;
      end
      default: begin
        tab = '0;
        n   = 0;
      end
    endcase
    for (int k = 0; k < 6; k++) begin
      if (!hit && k < n && p == tab[41-7*k -: 7]) begin
        hit = 1'b1;
        x   = 4'(10 + k);
      end
    end
    if (!hit) begin
      case (p)
        7'h00:        bl = 1'b1;
        7'h3F:        x  = 4'd0;
        7'h06:        x  = 4'd1;
        7'h5B:        x  = 4'd2;
        7'h4F:        x  = 4'd3;
        7'h66:        x  = 4'd4;
        7'h6D:        x  = 4'd5;
        7'h7D, 7'h7C: x  = 4'd6;
        7'h27, 7'h07: x  = 4'd7;
        7'h7F:        x  = 4'd8;
        7'h6F, 7'h67: x  = 4'd9;
        default: begin
          er = 1'b1;
          x  = 4'hF;
        end
      endcase
    end
    return {er, bl, x};
  endfunction

  always_comb begin
    pat  = al ? seg_s2_q : ~seg_s2_q;
    sel  = DIG_ACT_HIGH ? sel_s2_q : ~sel_s2_q;
    one  = $onehot(sel);
    same = (pat == pat_prev_q) && (sel == sel_prev_q);
    if (!one)
      run_d = 4'd0;
    else if (!same)
      run_d = 4'd1;
    else if (run_q == STB)
      run_d = run_q;
    else
      run_d = run_q + 4'd1;
    // Saturation at STB means a long dwell captures only once.
    capture   = one && (run_d == STB) && (run_q != STB);
    idx       = 3'd0;
    cur_val   = 4'd0;
    cur_blank = 1'b0;
    cur_err   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) begin
        idx       = 3'(i);
        cur_val   = val_q[4*i +: 4];
        cur_blank = blank_q[i];
        cur_err   = err_q[i];
      end
    end
    dec = decode(pat, version);
    chg = dec != {cur_err, cur_blank, cur_val};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      pat_prev_q <= '0;
      sel_prev_q <= '0;
      run_q      <= '0;
      val_q      <= '0;
      blank_q    <= '1;
      err_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_digit_q <= '0;
      ev_value_q <= '0;
      ev_blank_q <= 1'b0;
      ev_err_q   <= 1'b0;
      frame_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      sel_s1_q   <= dig_sel;
      sel_s2_q   <= sel_s1_q;
      pat_prev_q <= pat;
      sel_prev_q <= sel;
      run_q      <= run_d;
      frame_q    <= capture && sel[NUM_DIGITS-1];
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            val_q[4*i +: 4] <= dec[3:0];
            blank_q[i]      <= dec[4];
            err_q[i]        <= dec[5];
          end
        end
      end
      if (capture && chg && (!ev_valid_q || ev.out_ready)) begin
        ev_valid_q <= 1'b1;
        ev_digit_q <= idx;
        ev_value_q <= dec[3:0];
        ev_blank_q <= dec[4];
        ev_err_q   <= dec[5];
      end else if (ev_valid_q && ev.out_ready) begin
        ev_valid_q <= 1'b0;
      end
      if (capture && chg && ev_valid_q && !ev.out_ready)
        ovf_q <= 1'b1;
      else if (clr_ovf)
        ovf_q <= 1'b0;
    end
  end

  assign digit_value  = val_q;
  assign digit_blank  = blank_q;
  assign digit_err    = err_q;
  assign ev.out_valid = ev_valid_q;
  assign ev.out_digit = ev_digit_q;
  assign ev.out_value = ev_value_q;
  assign ev.out_blank = ev_blank_q;
  assign ev.out_err   = ev_err_q;
  assign frame_done   = frame_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: decode table vectors, event
// scoreboard, dwell timing, overflow and reset sequences.
module tb_seg_scan_reader;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [6:0]     seg_in = '0;
  logic [N-1:0]   dig_sel = '0;
  logic           al = 1'b1;
  logic [2:0]     version = '0;
  logic [4*N-1:0] digit_value;
  logic [N-1:0]   digit_blank, digit_err;
  logic           frame_done, ovf;
  logic           clr_ovf = 1'b0;

  seg_scan_reader_if ev_if();

  always #5 clk = ~clk;

  seg_scan_reader #(
    .NUM_DIGITS(N), .STABLE_CYCLES(3), .DIG_ACT_HIGH(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .al(al), .version(version), .digit_value(digit_value),
    .digit_blank(digit_blank), .digit_err(digit_err),
    .ev(ev_if), .frame_done(frame_done), .ovf(ovf),
    .clr_ovf(clr_ovf)
  );

  typedef struct {
    int         d;
    logic [6:0] seg;
    logic       a;
    logic [2:0] ver;
    logic [3:0] v;
    logic       b;
    logic       e;
  } vec_t;

  vec_t       tbl[15];
  int         errors = 0;
  int         checks = 0;
  int         frames = 0;
  int         exp_frames = 0;
  int         f0;
  logic [8:0] q[$];
  logic [8:0] got;
  logic [8:0] exp_ev;
  logic [3:0] m_val[N];
  logic       m_blank[N];
  logic       m_err[N];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i]   = 4'd0;
      m_blank[i] = 1'b1;
      m_err[i]   = 1'b0;
    end
  endtask

  task automatic expect_cap(int d, logic [3:0] v, logic b,
                            logic e, bit drop);
    if (d == N - 1) exp_frames++;
    if ({m_val[d], m_blank[d], m_err[d]} != {v, b, e} && !drop)
      q.push_back({3'(d), v, b, e});
    m_val[d]   = v;
    m_blank[d] = b;
    m_err[d]   = e;
  endtask

  task automatic drive(int d, logic [6:0] p, logic a,
                       logic [2:0] v, int hold);
    @(posedge clk);
    #1;
    seg_in  = p;
    dig_sel = 4'(1 << d);
    al      = a;
    version = v;
    repeat (hold) @(posedge clk);
  endtask

  task automatic scan(int d, logic [6:0] p, logic a,
                      logic [2:0] v, int hold);
    drive(d, p, a, v, hold);
    #1 dig_sel = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ready(logic r);
    @(posedge clk);
    #1 ev_if.out_ready = r;
  endtask

  // Scoreboard side: pop one expected event per transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) frames++;
      if (ev_if.out_valid && ev_if.out_ready) begin
        got = {ev_if.out_digit, ev_if.out_value,
               ev_if.out_blank, ev_if.out_err};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", got);
        end else begin
          exp_ev = q.pop_front();
          if (got !== exp_ev) begin
            errors++;
            $display("FAIL event: got %0h expected %0h", got, exp_ev);
          end
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{0, 7'h7C, 1'b1, 3'd7, 4'hB, 1'b0, 1'b0};
    tbl[1]  = '{0, 7'h7C, 1'b1, 3'd0, 4'h6, 1'b0, 1'b0};
    tbl[2]  = '{2, 7'h30, 1'b0, 3'd0, 4'h3, 1'b0, 1'b0};
    tbl[3]  = '{2, 7'h30, 1'b0, 3'd0, 4'h3, 1'b0, 1'b0};
    tbl[4]  = '{1, 7'h55, 1'b1, 3'd0, 4'hF, 1'b0, 1'b1};
    tbl[5]  = '{1, 7'h00, 1'b1, 3'd0, 4'h0, 1'b1, 1'b0};
    tbl[6]  = '{3, 7'h00, 1'b1, 3'd0, 4'h0, 1'b1, 1'b0};
    tbl[7]  = '{3, 7'h77, 1'b1, 3'd7, 4'hA, 1'b0, 1'b0};
    tbl[8]  = '{3, 7'h58, 1'b1, 3'd1, 4'hA, 1'b0, 1'b0};
    tbl[9]  = '{1, 7'h5C, 1'b1, 3'd2, 4'hA, 1'b0, 1'b0};
    tbl[10] = '{0, 7'h06, 1'b1, 3'd3, 4'h1, 1'b0, 1'b0};
    tbl[11] = '{2, 7'h40, 1'b1, 3'd5, 4'hA, 1'b0, 1'b0};
    tbl[12] = '{2, 7'h79, 1'b1, 3'd5, 4'hE, 1'b0, 1'b0};
    tbl[13] = '{0, 7'h67, 1'b1, 3'd0, 4'h9, 1'b0, 1'b0};
    tbl[14] = '{0, 7'h4C, 1'b1, 3'd0, 4'hF, 1'b0, 1'b1};
    model_reset();
    ev_if.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_value", 32'(digit_value), 32'h0);
    chk("rst_blank", 32'(digit_blank), 32'hF);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_valid", 32'(ev_if.out_valid), 32'h0);
    chk("rst_fields", {ev_if.out_digit, ev_if.out_value,
        ev_if.out_blank, ev_if.out_err}, 32'h0);
    chk("rst_frame", 32'(frame_done), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;

    // One sample short of the dwell: nothing captured.
    scan(1, 7'h06, 1'b1, 3'd0, 2);
    chk("short_blank", 32'(digit_blank[1]), 32'h1);
    chk("short_value", 32'(digit_value[7:4]), 32'h0);

    // Exact capture edge: t0 + 2 + STABLE_CYCLES.
    expect_cap(1, 4'h1, 1'b0, 1'b0, 1'b0);
    drive(1, 7'h06, 1'b1, 3'd0, 4);
    @(negedge clk);
    chk("lat_before", 32'(digit_value[7:4]), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_value", 32'(digit_value[7:4]), 32'h1);
    chk("lat_valid", 32'(ev_if.out_valid), 32'h1);
    repeat (8) @(posedge clk);
    #1 dig_sel = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      expect_cap(tbl[i].d, tbl[i].v, tbl[i].b, tbl[i].e, 1'b0);
      scan(tbl[i].d, tbl[i].seg, tbl[i].a, tbl[i].ver, 4);
      chk($sformatf("tbl%0d_value", i),
          32'(digit_value[4*tbl[i].d +: 4]), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_blank", i),
          32'(digit_blank[tbl[i].d]), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_err", i),
          32'(digit_err[tbl[i].d]), 32'(tbl[i].e));
    end

    // Two strobes at once never capture.
    f0 = frames;
    @(posedge clk);
    #1;
    seg_in  = 7'h06;
    dig_sel = 4'b0011;
    repeat (8) @(posedge clk);
    #1 dig_sel = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("multi_d0", 32'(digit_value[3:0]), 32'(m_val[0]));
    chk("multi_d1", 32'(digit_value[7:4]), 32'(m_val[1]));

    // Overflow while stalled, then clear.
    set_ready(1'b0);
    expect_cap(0, 4'h8, 1'b0, 1'b0, 1'b0);
    scan(0, 7'h7F, 1'b1, 3'd0, 4);
    chk("stall_valid", 32'(ev_if.out_valid), 32'h1);
    chk("stall_ovf", 32'(ovf), 32'h0);
    expect_cap(1, 4'h5, 1'b0, 1'b0, 1'b1);
    scan(1, 7'h6D, 1'b1, 3'd0, 4);
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_digit", 32'(ev_if.out_digit), 32'h0);
    chk("ovf_value", 32'(ev_if.out_value), 32'h8);
    chk("ovf_d1_upd", 32'(digit_value[7:4]), 32'h5);
    @(posedge clk);
    #1 clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 32'(ovf), 32'h0);

    // Capture on the same edge as a transfer.
    expect_cap(2, 4'h4, 1'b0, 1'b0, 1'b0);
    drive(2, 7'h66, 1'b1, 3'd0, 4);
    #1 ev_if.out_ready = 1'b1;
    @(posedge clk);
    #1 ev_if.out_ready = 1'b0;
    chk("coin_valid", 32'(ev_if.out_valid), 32'h1);
    chk("coin_digit", 32'(ev_if.out_digit), 32'h2);
    chk("coin_value", 32'(ev_if.out_value), 32'h4);
    chk("coin_ovf", 32'(ovf), 32'h0);
    repeat (2) @(posedge clk);
    #1 dig_sel = '0;
    set_ready(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("coin_drain", 32'(ev_if.out_valid), 32'h0);

    // Three back-to-back full scans.
    f0 = frames;
    for (int r = 0; r < 3; r++) begin
      expect_cap(0, 4'h0, 1'b0, 1'b0, 1'b0);
      drive(0, 7'h3F, 1'b1, 3'd0, 4);
      expect_cap(1, 4'h1, 1'b0, 1'b0, 1'b0);
      drive(1, 7'h06, 1'b1, 3'd0, 4);
      expect_cap(2, 4'h2, 1'b0, 1'b0, 1'b0);
      drive(2, 7'h5B, 1'b1, 3'd0, 4);
      expect_cap(3, 4'h3, 1'b0, 1'b0, 1'b0);
      drive(3, 7'h4F, 1'b1, 3'd0, 4);
    end
    #1 dig_sel = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("scan_frames", 32'(frames - f0), 32'd3);

    // Reset mid-handshake, with ovf set, during a dwell.
    set_ready(1'b0);
    expect_cap(3, 4'h0, 1'b0, 1'b0, 1'b1);
    scan(3, 7'h3F, 1'b1, 3'd0, 4);
    expect_cap(1, 4'h2, 1'b0, 1'b0, 1'b1);
    scan(1, 7'h5B, 1'b1, 3'd0, 4);
    chk("pre_rst_ovf", 32'(ovf), 32'h1);
    chk("pre_rst_valid", 32'(ev_if.out_valid), 32'h1);
    drive(0, 7'h06, 1'b1, 3'd0, 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_value", 32'(digit_value), 32'h0);
    chk("arst_blank", 32'(digit_blank), 32'hF);
    chk("arst_valid", 32'(ev_if.out_valid), 32'h0);
    chk("arst_fields", {ev_if.out_digit, ev_if.out_value,
        ev_if.out_blank, ev_if.out_err}, 32'h0);
    chk("arst_ovf", 32'(ovf), 32'h0);
    model_reset();
    q.delete();
    dig_sel = '0;
    @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);

    expect_cap(0, 4'h0, 1'b0, 1'b0, 1'b0);
    scan(0, 7'h3F, 1'b1, 3'd0, 4);
    chk("post_rst_val", 32'(digit_blank[0]), 32'h0);

    for (int k = 0; k < 50 && q.size() != 0; k++)
      @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    chk("frame_total", 32'(frames), 32'(exp_frames));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
